alarm_controller: RTL and testbench

Sequences the alarm datapath of the digital clock. It holds the programmable alarm time and presents it to the time comparator (AMPM1/HOUR1/MINHIGH1/MINLOW1 side), with the running clock driving the other side. It watches the comparator's SAME result and runs the ring/snooze state machine that drives the buzzer. It sits between the user push-button decoder, the 1 Hz tick generator and the comparator.

---
 rtl/alarm_controller_if.sv | 36 +++
 rtl/alarm_controller.sv | 152 +++++++++++++++
 tb/tb_alarm_controller.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_controller_if.sv
// alarm_controller_if
//   Groups the alarm controller's control inputs and alarm-time/buzzer outputs.
//   master: the surrounding clock logic (button decoder, 1 Hz tick, comparator)
//           drives the control inputs and reads the alarm time and buzzer state.
//   slave : the alarm_controller itself.
//
// Signal semantics: there is no valid/ready handshake on this bundle. tick,
// inc_hour, inc_min, snooze and stop are single-cycle pulses, sampled on the
// rising clock edge they are high for. same, alarm_en and set_mode are levels.
// All outputs are registered, or decoded from registers only.
interface alarm_controller_if;
    logic       tick;
    logic       same;
    logic       alarm_en;
    logic       set_mode;
    logic       inc_hour;
    logic       inc_min;
    logic       snooze;
    logic       stop;
    logic       al_ampm;
    logic [3:0] al_hour;
    logic [2:0] al_minhigh;
    logic [3:0] al_minlow;
    logic       buzz;
    logic [1:0] state;

    modport master (
        output tick, same, alarm_en, set_mode, inc_hour, inc_min, snooze, stop,
        input  al_ampm, al_hour, al_minhigh, al_minlow, buzz, state
    );

    modport slave (
        input  tick, same, alarm_en, set_mode, inc_hour, inc_min, snooze, stop,
        output al_ampm, al_hour, al_minhigh, al_minlow, buzz, state
    );
endinterface

// File: rtl/alarm_controller.sv
// alarm_controller
//   Holds the programmable alarm time (12-hour, BCD-style minutes) and runs the
//   ring/snooze state machine driving the buzzer.
//
// Ports:
//   clk  - system clock, all state updates on the rising edge
//   rst  - asynchronous, active-high reset
//   bus  - alarm_controller_if.slave:
//            in : tick, same, alarm_en, set_mode, inc_hour, inc_min, snooze, stop
//            out: al_ampm, al_hour (1..12), al_minhigh (0..5), al_minlow (0..9),
//                 buzz (high while ringing), state (00 DIS, 01 ARM, 10 RING, 11 SNZ)
//
// Parameters:
//   RING_SEC   - ticks the buzzer rings before stopping by itself (1..255)
//   SNOOZE_SEC - ticks spent snoozed before ringing again (1..65535)
module alarm_controller #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300
) (
    input logic               clk,
    input logic               rst,
    alarm_controller_if.slave bus
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_RINGING  = 2'b10,
        ST_SNOOZED  = 2'b11
    } state_t;

    localparam logic [7:0]  RING_LAST   = 8'(RING_SEC - 1);
    localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SEC - 1);

    state_t      state_q;
    logic        same_d;
    logic [7:0]  rcnt;
    logic [15:0] scnt;
    logic        trig;

    logic        al_ampm_q;
    logic [3:0]  al_hour_q;
    logic [2:0]  al_minhigh_q;
    logic [3:0]  al_minlow_q;

    // same stays high for the whole matching minute, so only its rising edge
    // starts a ring; otherwise stop would be undone on the very next cycle.
    // Editing suppresses the trigger because the alarm time is in flux.
    assign trig = bus.same & ~same_d & ~bus.set_mode;

    // Ring/snooze state machine. same_d resets to 1 so a comparator that is
    // already matching when reset releases cannot fire the alarm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DISABLED;
            same_d  <= 1'b1;
            rcnt    <= 8'd0;
            scnt    <= 16'd0;
        end else begin
            same_d <= bus.same;
            if (!bus.alarm_en) begin
                // Counters are left as-is; every entry into RINGING/SNOOZED clears them.
                state_q <= ST_DISABLED;
            end else begin
                unique case (state_q)
                    ST_DISABLED: begin
                        state_q <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (trig) begin
                            state_q <= ST_RINGING;
                            rcnt    <= 8'd0;
                        end
                    end
                    ST_RINGING: begin
                        if (bus.set_mode || bus.stop) begin
                            state_q <= ST_ARMED;
                        end else if (bus.snooze) begin
                            state_q <= ST_SNOOZED;
                            scnt    <= 16'd0;
                        end else if (bus.tick) begin
                            if (rcnt == RING_LAST) begin
                                state_q <= ST_ARMED;
                            end else begin
                                rcnt <= rcnt + 8'd1;
                            end
                        end
                    end
                    ST_SNOOZED: begin
                        // trig is deliberately not looked at here.
                        if (bus.set_mode || bus.stop) begin
                            state_q <= ST_ARMED;
                        end else if (bus.tick) begin
                            if (scnt == SNOOZE_LAST) begin
                                state_q <= ST_RINGING;
                                rcnt    <= 8'd0;
                            end else begin
                                scnt <= scnt + 16'd1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_DISABLED;
                    end
                endcase
            end
        end
    end

    // Alarm time editing. Hour and minute updates are independent, so both
    // apply when pulsed together; the minute wrap never carries into the hour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            al_ampm_q    <= 1'b0;
            al_hour_q    <= 4'd12;
            al_minhigh_q <= 3'd0;
            al_minlow_q  <= 4'd0;
        end else if (bus.set_mode) begin
            if (bus.inc_hour) begin
                if (al_hour_q == 4'd12) begin
                    al_hour_q <= 4'd1;
                end else if (al_hour_q == 4'd11) begin
                    // 11 -> 12 is where the 12-hour clock crosses noon/midnight.
                    al_hour_q <= 4'd12;
                    al_ampm_q <= ~al_ampm_q;
                end else begin
                    al_hour_q <= al_hour_q + 4'd1;
                end
            end
            if (bus.inc_min) begin
                if (al_minlow_q == 4'd9) begin
                    al_minlow_q <= 4'd0;
                    if (al_minhigh_q == 3'd5) begin
                        al_minhigh_q <= 3'd0;
                    end else begin
                        al_minhigh_q <= al_minhigh_q + 3'd1;
                    end
                end else begin
                    al_minlow_q <= al_minlow_q + 4'd1;
                end
            end
        end
    end

    assign bus.al_ampm    = al_ampm_q;
    assign bus.al_hour    = al_hour_q;
    assign bus.al_minhigh = al_minhigh_q;
    assign bus.al_minlow  = al_minlow_q;
    assign bus.state      = state_q;
    assign bus.buzz       = (state_q == ST_RINGING);

endmodule

// File: tb/tb_alarm_controller.sv
module tb_alarm_controller;

    localparam logic [1:0] S_DIS  = 2'b00;
    localparam logic [1:0] S_ARM  = 2'b01;
    localparam logic [1:0] S_RING = 2'b10;
    localparam logic [1:0] S_SNZ  = 2'b11;

    typedef struct {
        logic       en, set, ih, im, same, tick, snz, stp;
        logic       ampm;
        logic [3:0] hour;
        logic [2:0] mh;
        logic [3:0] ml;
        logic [1:0] st;
        logic       buzz;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alarm_controller_if bus ();

    alarm_controller #(
        .RING_SEC   (4),
        .SNOOZE_SEC (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs [16];

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en, input logic set, input logic ih, input logic im,
                         input logic same, input logic tick, input logic snz, input logic stp);
        bus.alarm_en = en;
        bus.set_mode = set;
        bus.inc_hour = ih;
        bus.inc_min  = im;
        bus.same     = same;
        bus.tick     = tick;
        bus.snooze   = snz;
        bus.stop     = stp;
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic en, input logic set, input logic ih, input logic im,
                        input logic same, input logic tick, input logic snz, input logic stp);
        drive(en, set, ih, im, same, tick, snz, stp);
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic expect_out(input string name, input logic ampm, input logic [3:0] hour,
                              input logic [2:0] mh, input logic [3:0] ml,
                              input logic [1:0] st, input logic buzz);
        logic [14:0] act;
        logic [14:0] exp;
        act = {bus.al_ampm, bus.al_hour, bus.al_minhigh, bus.al_minlow, bus.state, bus.buzz};
        exp = {ampm, hour, mh, ml, st, buzz};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got ampm=%0d hour=%0d min=%0d%0d state=%b buzz=%0d, want ampm=%0d hour=%0d min=%0d%0d state=%b buzz=%0d",
                     name, bus.al_ampm, bus.al_hour, bus.al_minhigh, bus.al_minlow, bus.state, bus.buzz,
                     ampm, hour, mh, ml, st, buzz);
        end
    endtask

    function automatic vec_t mkv(input logic en, input logic set, input logic ih, input logic im,
                                 input logic same, input logic tick, input logic snz, input logic stp,
                                 input logic ampm, input logic [3:0] hour, input logic [2:0] mh,
                                 input logic [3:0] ml, input logic [1:0] st, input logic buzz);
        vec_t v;
        v.en = en; v.set = set; v.ih = ih; v.im = im;
        v.same = same; v.tick = tick; v.snz = snz; v.stp = stp;
        v.ampm = ampm; v.hour = hour; v.mh = mh; v.ml = ml; v.st = st; v.buzz = buzz;
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        //               en set ih im sm tk sz sp | ampm hour mh ml  state  buzz
        vecs[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 0,   0, 12, 0, 0, S_DIS,  0);
        vecs[1]  = mkv(1, 0, 0, 0, 0, 0, 0, 0,   0, 12, 0, 0, S_ARM,  0);
        vecs[2]  = mkv(1, 1, 1, 0, 0, 0, 0, 0,   0,  1, 0, 0, S_ARM,  0);
        vecs[3]  = mkv(1, 1, 1, 0, 0, 0, 0, 0,   0,  2, 0, 0, S_ARM,  0);
        vecs[4]  = mkv(1, 1, 1, 0, 0, 0, 0, 0,   0,  3, 0, 0, S_ARM,  0);
        vecs[5]  = mkv(1, 1, 0, 0, 0, 0, 0, 0,   0,  3, 0, 0, S_ARM,  0);
        vecs[6]  = mkv(1, 0, 1, 0, 0, 0, 0, 0,   0,  3, 0, 0, S_ARM,  0); // inc ignored
        vecs[7]  = mkv(1, 1, 0, 1, 0, 0, 0, 0,   0,  3, 0, 1, S_ARM,  0);
        vecs[8]  = mkv(1, 1, 1, 1, 0, 0, 0, 0,   0,  4, 0, 2, S_ARM,  0); // both apply
        vecs[9]  = mkv(1, 0, 0, 0, 1, 0, 0, 0,   0,  4, 0, 2, S_RING, 1); // rise -> ring
        vecs[10] = mkv(1, 0, 0, 0, 1, 1, 0, 0,   0,  4, 0, 2, S_RING, 1);
        vecs[11] = mkv(1, 1, 0, 0, 1, 0, 0, 0,   0,  4, 0, 2, S_ARM,  0); // set_mode cancels
        vecs[12] = mkv(1, 0, 0, 0, 1, 0, 0, 0,   0,  4, 0, 2, S_ARM,  0); // no re-ring
        vecs[13] = mkv(0, 0, 0, 0, 1, 0, 0, 0,   0,  4, 0, 2, S_DIS,  0);
        vecs[14] = mkv(1, 0, 0, 0, 1, 0, 0, 0,   0,  4, 0, 2, S_ARM,  0); // enable while same=1
        vecs[15] = mkv(1, 0, 0, 0, 1, 0, 0, 0,   0,  4, 0, 2, S_ARM,  0);

        // Reset, checked while still asserted.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 0, 4'd12, 3'd0, 4'd0, S_DIS, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven vectors.
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].en, vecs[i].set, vecs[i].ih, vecs[i].im,
                 vecs[i].same, vecs[i].tick, vecs[i].snz, vecs[i].stp);
            expect_out($sformatf("vec%0d", i), vecs[i].ampm, vecs[i].hour, vecs[i].mh,
                       vecs[i].ml, vecs[i].st, vecs[i].buzz);
        end

        // Hours 4 -> 11 AM, then 12 PM (toggle), then 1 PM (no toggle).
        for (int k = 1; k <= 7; k++) begin
            step(1, 1, 1, 0, 0, 0, 0, 0);
            expect_out($sformatf("hour_inc%0d", k), 0, 4'(4 + k), 3'd0, 4'd2, S_ARM, 0);
        end
        step(1, 1, 1, 0, 0, 0, 0, 0);
        expect_out("hour_11_to_12pm", 1, 4'd12, 3'd0, 4'd2, S_ARM, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        expect_out("hour_12_to_1pm", 1, 4'd1, 3'd0, 4'd2, S_ARM, 0);

        // Minutes: reset to 12:00 AM, then 60 increments around the full range.
        rst = 1'b1;
        #1;
        expect_out("reset_sync_point", 0, 4'd12, 3'd0, 4'd0, S_DIS, 0);
        rst = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step(1, 1, 0, 1, 0, 0, 0, 0);
            expect_out($sformatf("min_inc%0d", k), 0, 4'd12, 3'((k % 60) / 10), 4'(k % 10), S_ARM, 0);
        end

        // Ring duration with RING_SEC=4, same held high across ten ticks.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        expect_out("arm_idle", 0, 4'd12, 3'd0, 4'd0, S_ARM, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        expect_out("ring_start", 0, 4'd12, 3'd0, 4'd0, S_RING, 1);
        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 0, 0, 1, 1, 0, 0);
            expect_out($sformatf("ring_tick%0d", i), 0, 4'd12, 3'd0, 4'd0,
                       (i < 4) ? S_RING : S_ARM, (i < 4) ? 1'b1 : 1'b0);
            step(1, 0, 0, 0, 1, 0, 0, 0);
            expect_out($sformatf("ring_gap%0d", i), 0, 4'd12, 3'd0, 4'd0,
                       (i < 4) ? S_RING : S_ARM, (i < 4) ? 1'b1 : 1'b0);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        expect_out("same_low", 0, 4'd12, 3'd0, 4'd0, S_ARM, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        expect_out("re_ring", 0, 4'd12, 3'd0, 4'd0, S_RING, 1);

        // Snooze with SNOOZE_SEC=3; same edges ignored while snoozed.
        step(1, 0, 0, 0, 1, 0, 1, 0);
        expect_out("snooze", 0, 4'd12, 3'd0, 4'd0, S_SNZ, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        expect_out("snz_same_low", 0, 4'd12, 3'd0, 4'd0, S_SNZ, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        expect_out("snz_trig_ignored", 0, 4'd12, 3'd0, 4'd0, S_SNZ, 0);
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 0, 0, 1, 1, 0, 0);
            expect_out($sformatf("snz_tick%0d", i), 0, 4'd12, 3'd0, 4'd0,
                       (i < 3) ? S_SNZ : S_RING, (i < 3) ? 1'b0 : 1'b1);
        end
        step(1, 0, 0, 0, 1, 0, 0, 1);
        expect_out("stop", 0, 4'd12, 3'd0, 4'd0, S_ARM, 0);

        // Simultaneous events while ringing.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        expect_out("ring_b", 0, 4'd12, 3'd0, 4'd0, S_RING, 1);
        step(1, 0, 0, 0, 1, 0, 1, 1);
        expect_out("stop_and_snooze", 0, 4'd12, 3'd0, 4'd0, S_ARM, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        expect_out("ring_c", 0, 4'd12, 3'd0, 4'd0, S_RING, 1);
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 0, 0, 1, 1, 0, 0);
            expect_out($sformatf("ring_c_tick%0d", i), 0, 4'd12, 3'd0, 4'd0, S_RING, 1);
        end
        step(1, 0, 0, 0, 1, 1, 1, 0);
        expect_out("snooze_and_final_tick", 0, 4'd12, 3'd0, 4'd0, S_SNZ, 0);
        step(1, 0, 0, 0, 1, 0, 0, 1);
        expect_out("stop_from_snooze", 0, 4'd12, 3'd0, 4'd0, S_ARM, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        expect_out("ring_d", 0, 4'd12, 3'd0, 4'd0, S_RING, 1);
        step(1, 0, 0, 0, 1, 1, 0, 1);
        expect_out("stop_and_tick", 0, 4'd12, 3'd0, 4'd0, S_ARM, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        expect_out("ring_e", 0, 4'd12, 3'd0, 4'd0, S_RING, 1);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        expect_out("disable_mid_ring", 0, 4'd12, 3'd0, 4'd0, S_DIS, 0);

        // Asynchronous reset mid-ring with a non-default alarm time.
        step(1, 1, 1, 1, 0, 0, 0, 0);
        expect_out("edit_1_01", 0, 4'd1, 3'd0, 4'd1, S_ARM, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        expect_out("ring_f", 0, 4'd1, 3'd0, 4'd1, S_RING, 1);
        #3;
        rst = 1'b1;
        #1;
        expect_out("async_reset", 0, 4'd12, 3'd0, 4'd0, S_DIS, 0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_out("post_reset_arm", 0, 4'd12, 3'd0, 4'd0, S_ARM, 0);
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 0, 0, 1, 0, 0, 0);
            expect_out($sformatf("post_reset_no_ring%0d", i), 0, 4'd12, 3'd0, 4'd0, S_ARM, 0);
        end

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
